// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_pkg
// Purpose  : Shared types and constants for the spi_master block: FSM state
//            encoding, SPI mode encodings and edge-counter sizing.
// Revision : 1.0 - initial release
// ============================================================================
package spi_pkg;

  // Transfer sequencing states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    XFER  = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_t;

  // SPI modes encoded as {cpol, cpha}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  // Edge counter must hold 0..2*data_w
  function automatic int edge_cnt_w(input int data_w);
    return $clog2(2 * data_w + 1);
  endfunction

  localparam int EDGE_CNT_W = edge_cnt_w(8);

endpackage
`default_nettype wire

// File: rtl/spi_clk_gen.sv
`default_nettype none
// ============================================================================
// Module   : spi_clk_gen
// Purpose  : Half-period divider and SCLK level generator for spi_master.
//            tick marks the last clk cycle of each H-cycle half-period;
//            pre_tick marks the cycle before it (used to shorten GAP).
// Revision : 1.0 - initial release
// ============================================================================
module spi_clk_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  input  logic             force_lvl,
  input  logic             lvl,
  input  logic             toggle,
  output logic             tick,
  output logic             pre_tick,
  output logic             sclk
);

  logic [DIV_W-1:0] cnt;

  assign tick     = run && (cnt == div);
  assign pre_tick = run && ((cnt + DIV_W'(1)) == div);

  // Divider: counts 0..div while running, restarts on every wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!run || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

  // SCLK: parked at the polarity level outside the toggling phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk <= 1'b0;
    end else if (force_lvl) begin
      sclk <= lvl;
    end else if (toggle) begin
      sclk <= ~sclk;
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
// Module   : spi_master
// Purpose  : SPI bus master, all four modes, one DATA_W word per handshake.
//            Optional macro SPI_MASTER_LSB_FIRST_EN adds the lsb_first input.
// Revision : 1.0 - initial release
// ============================================================================
module spi_master #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
`ifdef SPI_MASTER_LSB_FIRST_EN
  input  logic              lsb_first,
`endif
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic              cs_n
);
  import spi_pkg::*;

  localparam int ECW = edge_cnt_w(DATA_W);
  localparam logic [ECW-1:0] LAST_EDGE = ECW'(2 * DATA_W);

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic              cpol_l;
  logic              cpha_l;
  logic [DIV_W-1:0]  div_l;
  logic [ECW-1:0]    edge_cnt;
  logic [ECW-1:0]    next_edge;
  logic              tick;
  logic              pre_tick;
  logic              toggling;
  logic              sample_now;
  logic              drive_now;
  logic              lsb_acc;
  logic              lsb_cur;

`ifdef SPI_MASTER_LSB_FIRST_EN
  assign lsb_acc = lsb_first;

  // Bit order is frozen at accept like the other controls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lsb_cur <= 1'b0;
    end else if (state == IDLE && tx_valid) begin
      lsb_cur <= lsb_first;
    end
  end
`else
  assign lsb_acc = 1'b0;
  assign lsb_cur = 1'b0;
`endif

  function automatic logic out_bit(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w,
                                                 input logic b, input logic lsb);
    return lsb ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
  endfunction

  assign tx_ready  = (state == IDLE);
  assign toggling  = (state == SETUP) || (state == XFER);
  assign next_edge = edge_cnt + ECW'(1);
  // cpha=0 samples on odd edges, cpha=1 on even; the opposite edges drive,
  // except that cpha=0 never drives on the final edge
  assign sample_now = cpha_l ? ~next_edge[0] : next_edge[0];
  assign drive_now  = cpha_l ? next_edge[0]
                             : (~next_edge[0] && (next_edge != LAST_EDGE));

  spi_clk_gen #(.DIV_W(DIV_W)) u_clk_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (state != IDLE),
    .div       (div_l),
    .force_lvl (!toggling),
    .lvl       ((state == IDLE) ? cpol : cpol_l),
    .toggle    (tick && toggling),
    .tick      (tick),
    .pre_tick  (pre_tick),
    .sclk      (sclk)
  );

  // Transfer FSM, shift register and registered pin/result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cs_n     <= 1'b1;
      mosi     <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      shreg    <= '0;
      cpol_l   <= 1'b0;
      cpha_l   <= 1'b0;
      div_l    <= '0;
      edge_cnt <= '0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_valid) begin
            shreg    <= tx_data;
            cpol_l   <= cpol;
            cpha_l   <= cpha;
            div_l    <= clk_div;
            edge_cnt <= '0;
            cs_n     <= 1'b0;
            if (!cpha) begin
              mosi <= out_bit(tx_data, lsb_acc);
            end
            state <= SETUP;
          end
        end
        SETUP, XFER: begin
          if (tick) begin
            edge_cnt <= next_edge;
            if (sample_now) begin
              shreg <= shift_in(shreg, miso, lsb_cur);
            end
            if (drive_now) begin
              mosi <= out_bit(shreg, lsb_cur);
            end
            if (state == SETUP) begin
              state <= XFER;
            end else if (next_edge == LAST_EDGE) begin
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (tick) begin
            cs_n     <= 1'b1;
            rx_data  <= shreg;
            rx_valid <= 1'b1;
            // The accept cycle in IDLE is the last of the H cs_n-high cycles
            state    <= (div_l == '0) ? IDLE : GAP;
          end
        end
        GAP: begin
          if (pre_tick) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
